fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake that tolerates variable latency.
- Buffers returned instructions, each paired with its PC+4, in a small FIFO.
- Flushes the FIFO and retargets the PC on a branch/jump redirect coming from EX/MEM.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h00000000, PC value loaded at reset; bits [1:0] must be 0.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- imem_req, output, 1, read request; held high until imem_ack.
- imem_addr, output, 32, word address of the request; stable while imem_req=1.
- imem_ack, input, 1, response valid; sampled only while imem_req=1.
- imem_rdata, input, 32, instruction word; valid when imem_ack=1.
- redirect_valid, input, 1, single-cycle pulse requesting a flush and retarget.
- redirect_pc, input, 32, new PC; bits [1:0] are treated as 0.
- inst_valid, output, 1, FIFO head is valid.
- inst_ready, input, 1, consumer accepts the head.
- inst_out, output, 32, head instruction.
- pc4_out, output, 32, head PC+4.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, FIFO empty (count=0), state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, pc4_out=0.
- FSM states: IDLE, WAIT, DROP. All outputs are registered except inst_valid, inst_out and pc4_out, which decode combinationally from the FIFO head. inst_valid = (count != 0).
- IDLE:
  - If redirect_valid=0 and count < DEPTH: next edge sets imem_req=1 and imem_addr=pc, and goes to WAIT.
  - Otherwise: stay in IDLE.
- Slot reservation: occupancy = count + (state==WAIT). A new request issues only while occupancy < DEPTH. A pop in the same cycle does not free a slot for issue until the following cycle. The FIFO therefore never overflows.
- WAIT with imem_ack=1 and no redirect:
  - Push {imem_rdata, pc+4}; pc <= pc+4.
  - If count+1 < DEPTH: keep imem_req=1 with imem_addr=pc+4 and stay in WAIT (back-to-back, one fetch per cycle with zero-wait memory).
  - Else: imem_req=0 and go to IDLE.
- WAIT with imem_ack=0: hold imem_req and imem_addr.
- redirect_valid=1 (highest priority, any state):
  - FIFO cleared (count=0, head/tail reset); pc <= {redirect_pc[31:2], 2'b00}. Any same-cycle pop or push is discarded.
  - In WAIT with imem_ack=0: go to DROP. imem_req stays high because an outstanding request cannot be aborted.
  - In WAIT with imem_ack=1: the response is discarded; imem_req=0; go to IDLE.
  - In DROP: pc is updated and the state stays DROP.
  - In IDLE: stay in IDLE; the new PC issues on the next eligible cycle.
- DROP: on imem_ack the data is discarded, imem_req=0, and the state goes to IDLE. No push occurs.
- Pop: inst_valid & inst_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Latency:
  - Request at cycle N, ack at cycle N+k: inst_valid is high at N+k+1.
  - Minimum reset-release to first inst_valid is 2 edges.
- Arithmetic: PC wraps modulo 2^32 (32'hFFFFFFFC + 4 = 0); pc4_out wraps identically.
- Reset asserted mid-operation clears everything immediately. An in-flight memory response arriving after rst_n deasserts is ignored, because imem_req=0 means imem_ack is not sampled.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds two output ports.
  - perf_fetch [15:0]: increments on every push.
  - perf_drop [15:0]: increments on every discarded response (DROP ack or redirect-with-ack) plus every valid entry flushed by redirect.
  - Both reset to 0 and wrap at 16'hFFFF -> 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, zero-wait ack, inst_ready=1, memory returning addr-derived data -> imem_addr sequence 0,4,8,C on consecutive cycles; inst_out/pc4_out pairs (d0,4),(d4,8),(d8,C).
- inst_ready=0, DEPTH=4, zero-wait ack -> exactly 4 pushes, then imem_req=0 with count=4. Raise inst_ready for 1 cycle -> one pop, and a new request issues the following cycle at addr 0x10.
- 3-cycle ack latency; redirect_valid pulse with redirect_pc=0x103 one cycle after the request -> state DROP, late data not pushed, next imem_addr=0x100, inst_valid=0 until that response returns.
- redirect_valid coincident with imem_ack while 2 entries are queued -> FIFO empty next cycle, response discarded, next request to redirect_pc.
- RESET_PC=32'hFFFFFFF8, zero-wait ack -> addresses FFFFFFF8, FFFFFFFC, 0; pc4_out values FFFFFFFC, 0, 4.
- rst_n asserted while in WAIT with 3 entries queued -> inst_valid=0 and imem_req=0 immediately (asynchronous). After release, fetch restarts at RESET_PC; perf_fetch=0 when FETCH_PERF_CNT_EN is defined.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, fetches over req/ack and buffers {inst, pc+4} in a FIFO.
// Optional perf counters (perf_fetch, perf_drop) are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] pc4_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] perf_fetch,
   output logic [15:0] perf_drop
`endif
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_pc, w_pc_nxt;
   logic          r_req, w_req_nxt;
   logic [31:0]   r_addr, w_addr_nxt;
   logic [AW-1:0] r_head, r_tail;
   logic [CW-1:0] r_count;
   logic [31:0]   r_inst [DEPTH];
   logic [31:0]   r_pc4  [DEPTH];
   logic          w_push, w_pop;
   logic [31:0]   w_pc4;

   assign w_pc4      = r_pc + 32'd4;
   assign inst_valid = (r_count != '0);
   assign w_pop      = inst_valid & inst_ready & ~redirect_valid;
   assign inst_out   = inst_valid ? r_inst[r_head] : '0;
   assign pc4_out    = inst_valid ? r_pc4[r_head]  : '0;
   assign imem_req   = r_req;
   assign imem_addr  = r_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_req   <= 1'b0;
         r_addr  <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_req   <= w_req_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // r_pc always names the outstanding request while in WAIT; it advances only on an accepted ack.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_req;
      w_addr_nxt  = r_addr;
      w_pc_nxt    = r_pc;
      w_push      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!redirect_valid && (r_count < L_DEPTH)) begin
               w_state_nxt = S_WAIT;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = r_pc;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               if (imem_ack) begin
                  w_state_nxt = S_IDLE;
                  w_req_nxt   = 1'b0;
               end else begin
                  w_state_nxt = S_DROP;
               end
            end else if (imem_ack) begin
               w_push   = 1'b1;
               w_pc_nxt = w_pc4;
               if ((r_count + CW'(1)) < L_DEPTH) begin
                  w_addr_nxt = w_pc4;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_req_nxt   = 1'b0;
               end
            end
         end
         S_DROP: begin
            // The request already in flight must complete before a new one can issue.
            if (imem_ack) begin
               w_state_nxt = S_IDLE;
               w_req_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
      if (redirect_valid) begin
         w_pc_nxt = redirect_pc & 32'hFFFF_FFFC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect_valid) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + AW'(1);
         if (w_pop)  r_head <= r_head + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_tail] <= imem_rdata;
         r_pc4[r_tail]  <= w_pc4;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] r_perf_fetch, r_perf_drop;
   logic        w_rsp_drop;
   logic [15:0] w_drop_inc;

   assign w_rsp_drop = imem_ack & ((r_state == S_DROP) | ((r_state == S_WAIT) & redirect_valid));
   assign w_drop_inc = 16'(w_rsp_drop) + (redirect_valid ? 16'(r_count) : 16'd0);
   assign perf_fetch = r_perf_fetch;
   assign perf_drop  = r_perf_drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_fetch <= '0;
         r_perf_drop  <= '0;
      end else begin
         r_perf_fetch <= r_perf_fetch + 16'(w_push);
         r_perf_drop  <= r_perf_drop + w_drop_inc;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: reset/zero-wait table, directed corner sequences, random run vs queue model.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req, imem_ack, redirect_valid, inst_valid, inst_ready;
   logic [31:0] imem_addr, imem_rdata, redirect_pc, inst_out, pc4_out;
   logic        req1, ack1, redir1, valid1, ready1;
   logic [31:0] addr1, rdata1, rpc1, inst1, pc41;
`ifdef FETCH_PERF_CNT_EN
   logic [15:0] perf_fetch, perf_drop, perf_fetch1, perf_drop1;
`endif

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_out(inst_out), .pc4_out(pc4_out)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch(perf_fetch), .perf_drop(perf_drop)
`endif
   );

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .imem_req(req1), .imem_addr(addr1),
      .imem_ack(ack1), .imem_rdata(rdata1), .redirect_valid(redir1),
      .redirect_pc(rpc1), .inst_valid(valid1), .inst_ready(ready1),
      .inst_out(inst1), .pc4_out(pc41)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch(perf_fetch1), .perf_drop(perf_drop1)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc, m_addr;
   bit          m_req, m_drop;
   logic [15:0] m_pf, m_pd;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset(input logic [31:0] rpc);
      mq.delete();
      m_pc = rpc; m_addr = rpc; m_req = 0; m_drop = 0; m_pf = '0; m_pd = '0;
   endfunction

   // Advance the reference by one clock using the inputs currently driven.
   function automatic void model_step();
      int   n = mq.size();
      bit   ack = m_req && (imem_ack === 1'b1);
      bit   pop = (n != 0) && inst_ready && !redirect_valid;
      ent_t e;
      if (redirect_valid) begin
         m_pd += 16'(n) + (ack ? 16'd1 : 16'd0);
         mq.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
         if (ack) begin
            m_req = 0; m_drop = 0;
         end else if (m_req) begin
            m_drop = 1;
         end
      end else begin
         if (pop) void'(mq.pop_front());
         if (ack && m_drop) begin
            m_req = 0; m_drop = 0; m_pd += 16'd1;
         end else if (ack) begin
            e.inst = imem_rdata;
            e.pc4  = m_pc + 32'd4;
            mq.push_back(e);
            m_pf += 16'd1;
            m_pc = m_pc + 32'd4;
            if (n + 1 < DEPTH) m_addr = m_pc;
            else m_req = 0;
         end else if (!m_req && n < DEPTH) begin
            m_req = 1; m_addr = m_pc;
         end
      end
   endfunction

   task automatic check_model();
      chk("req", imem_req, m_req);
      if (m_req) chk("addr", imem_addr, m_addr);
      chk("valid", inst_valid, mq.size() != 0);
      chk("inst", inst_out, (mq.size() != 0) ? mq[0].inst : 32'h0);
      chk("pc4", pc4_out, (mq.size() != 0) ? mq[0].pc4 : 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch, m_pf);
      chk("perf_drop", perf_drop, m_pd);
`endif
   endtask

   task automatic mem_ack(input bit en);
      imem_ack   = en && imem_req;
      imem_rdata = mdata(imem_addr);
   endtask

   task automatic step();
      ack1   = req1;
      rdata1 = mdata(addr1);
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      imem_ack = 1'b0; imem_rdata = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      ack1 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset(32'h0);
      check_model();
   endtask

   typedef struct {
      bit          ready;
      bit          ack_en;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_inst;
      logic [31:0] e_pc4;
      logic [31:0] e_addr1;
      logic [31:0] e_pc41;
   } vec_t;

   vec_t vt[5];

   initial begin
      vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,      32'h0, 32'hFFFF_FFF8, 32'h0};
      vt[1] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0,      32'h0, 32'hFFFF_FFF8, 32'h0};
      vt[2] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, mdata(32'h0), 32'h4, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
      vt[3] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, mdata(32'h4), 32'h8, 32'h0,         32'h0};
      vt[4] = '{1'b1, 1'b1, 1'b1, 32'hC, 1'b1, mdata(32'h8), 32'hC, 32'h4,         32'h4};

      redir1 = 1'b0; rpc1 = '0; ready1 = 1'b1; ack1 = 1'b0; rdata1 = '0;
      rst_n = 1'b0;

      // Zero-wait streaming from reset on both instances.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("tbl%0d_req", i),   imem_req,   vt[i].e_req);
         chk($sformatf("tbl%0d_addr", i),  imem_addr,  vt[i].e_addr);
         chk($sformatf("tbl%0d_valid", i), inst_valid, vt[i].e_valid);
         chk($sformatf("tbl%0d_inst", i),  inst_out,   vt[i].e_inst);
         chk($sformatf("tbl%0d_pc4", i),   pc4_out,    vt[i].e_pc4);
         chk($sformatf("tbl%0d_addr1", i), addr1,      vt[i].e_addr1);
         chk($sformatf("tbl%0d_pc41", i),  pc41,       vt[i].e_pc41);
         inst_ready = vt[i].ready;
         redirect_valid = 1'b0;
         mem_ack(vt[i].ack_en);
         step();
      end

      // Fill to DEPTH with consumer stalled, then one pop and a reissue.
      do_reset();
      inst_ready = 1'b0;
      repeat (5) begin mem_ack(1); step(); end
      chk("full_req", imem_req, 1'b0);
      chk("full_head", inst_out, mdata(32'h0));
      inst_ready = 1'b1; mem_ack(1); step();
      chk("pop_req", imem_req, 1'b0);
      chk("pop_head", inst_out, mdata(32'h4));
      inst_ready = 1'b0; mem_ack(1); step();
      chk("reissue_req", imem_req, 1'b1);
      chk("reissue_addr", imem_addr, 32'h10);

      // Redirect while a 3-cycle request is outstanding.
      do_reset();
      inst_ready = 1'b1;
      mem_ack(0); step();
      redirect_valid = 1'b1; redirect_pc = 32'h103; mem_ack(0); step();
      redirect_valid = 1'b0;
      chk("drop_req_held", imem_req, 1'b1);
      chk("drop_addr_held", imem_addr, 32'h0);
      mem_ack(0); step();
      mem_ack(1); step();
      chk("drop_nopush", inst_valid, 1'b0);
      chk("drop_req_low", imem_req, 1'b0);
      mem_ack(0); step();
      chk("redir_req", imem_req, 1'b1);
      chk("redir_addr", imem_addr, 32'h100);
      mem_ack(0); step();
      chk("redir_wait_valid", inst_valid, 1'b0);
      mem_ack(1); step();
      chk("redir_valid", inst_valid, 1'b1);
      chk("redir_inst", inst_out, mdata(32'h100));
      chk("redir_pc4", pc4_out, 32'h104);

      // Redirect coincident with ack while two entries are queued.
      do_reset();
      inst_ready = 1'b0;
      repeat (3) begin mem_ack(1); step(); end
      redirect_valid = 1'b1; redirect_pc = 32'h200; mem_ack(1); step();
      redirect_valid = 1'b0;
      chk("rack_valid", inst_valid, 1'b0);
      chk("rack_req", imem_req, 1'b0);
      mem_ack(1); step();
      chk("rack_reissue_req", imem_req, 1'b1);
      chk("rack_reissue_addr", imem_addr, 32'h200);

      // Asynchronous reset in WAIT with three entries queued.
      do_reset();
      inst_ready = 1'b0;
      repeat (4) begin mem_ack(1); step(); end
      chk("pre_rst_valid", inst_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", inst_valid, 1'b0);
      chk("async_req", imem_req, 1'b0);
      chk("async_addr", imem_addr, 32'h0);
      model_reset(32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      chk("restart_req", imem_req, 1'b1);
      chk("restart_addr", imem_addr, 32'h0);
      chk("restart_valid", inst_valid, 1'b0);
`ifdef FETCH_PERF_CNT_EN
      chk("restart_perf", perf_fetch, 16'h0);
`endif

      // Random traffic against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         inst_ready     = ($urandom_range(3) != 0);
         redirect_valid = ($urandom_range(19) == 0);
         redirect_pc    = $urandom;
         imem_ack       = imem_req && ($urandom_range(2) == 0);
         imem_rdata     = $urandom;
         step();
      end
      redirect_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
